// File: rtl/fifo_stream_reader.sv
// Read-side engine for the synchronous FIFO: pops against pndng, captures the
// registered DataOut into a 3-entry skid buffer and presents it as a valid/ready stream.
module fifo_stream_reader #(
    parameter int WS = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_fifo,
    input  logic          start,
    input  logic [CW-1:0] burst_len,
    input  logic          stop,
    input  logic          fifo_pndng,
    input  logic [WS-1:0] fifo_data,
    output logic          fifo_pop,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [WS-1:0] m_data,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] words_sent
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          continuous;
    logic [CW-1:0] remaining;
    logic          inflight;
    logic [WS-1:0] skid [3];
    logic [1:0]    buf_cnt;
    logic [1:0]    wr_idx;
    logic [2:0]    occupancy;
    logic          handshake;

    // Words already owed to the buffer (stored plus the one arriving from the FIFO)
    // bound further pops, so m_ready never reaches fifo_pop combinationally.
    assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight};
    assign fifo_pop  = (state == DRAIN) && fifo_pndng && !stop && (occupancy < 3'd3)
                       && (continuous || (remaining != '0));

    assign m_valid   = (buf_cnt != 2'd0);
    assign m_data    = skid[0];
    assign handshake = m_valid && m_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign wr_idx    = buf_cnt - {1'b0, handshake};

    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRAIN;
            DRAIN:   if (stop || (!continuous && fifo_pop && (remaining == CW'(1))))
                         state_nxt = FLUSH;
            FLUSH:   if (!inflight && (buf_cnt == 2'd0)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset_fifo) begin
        if (reset_fifo) begin
            state      <= IDLE;
            continuous <= 1'b0;
            remaining  <= '0;
            inflight   <= 1'b0;
            words_sent <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_pop;
            if ((state == IDLE) && start) begin
                remaining  <= burst_len;
                continuous <= (burst_len == '0);
                words_sent <= '0;
            end else begin
                if (fifo_pop && !continuous) remaining <= remaining - CW'(1);
                if (handshake) words_sent <= words_sent + CW'(1);
            end
        end
    end

    // Head always sits in skid[0] so m_data comes straight from a register;
    // a handshake shifts the queue down, a capture lands behind the last kept word.
    // NOTE: the buffer is reset because skid[0] is the m_data output, which must read 0 after reset.
    always_ff @(posedge clk or posedge reset_fifo) begin
        if (reset_fifo) begin
            buf_cnt <= 2'd0;
            skid[0] <= '0;
            skid[1] <= '0;
            skid[2] <= '0;
        end else begin
            case ({inflight, handshake})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase

            if (inflight && (wr_idx == 2'd0))  skid[0] <= fifo_data;
            else if (handshake)                skid[0] <= skid[1];

            if (inflight && (wr_idx == 2'd1))  skid[1] <= fifo_data;
            else if (handshake)                skid[1] <= skid[2];

            if (inflight && (wr_idx == 2'd2))  skid[2] <= fifo_data;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, push-order scoreboard and
// stream-protocol monitor, directed scenarios followed by a randomized run.
module tb_fifo_stream_reader;

    localparam int WS = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_fifo = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic          stop = 1'b0;
    logic          fifo_pndng;
    logic [WS-1:0] fifo_data;
    logic          fifo_pop;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [WS-1:0] m_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_sent;

    logic          push = 1'b0;
    logic [WS-1:0] push_data = '0;
    logic [WS-1:0] fifo_q [$];
    logic [WS-1:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int pop_total = 0;
    int hs_total = 0;
    int occ = 0;
    logic          stall_prev = 1'b0;
    logic [WS-1:0] held_data = '0;
    logic          rand_done = 1'b0;

    fifo_stream_reader #(.WS(WS), .CW(CW)) dut (
        .clk        (clk),
        .reset_fifo (reset_fifo),
        .start      (start),
        .burst_len  (burst_len),
        .stop       (stop),
        .fifo_pndng (fifo_pndng),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    // Depth-8 synchronous FIFO with registered DataOut and pndng.
    always @(posedge clk or posedge reset_fifo) begin
        if (reset_fifo) begin
            fifo_q.delete();
            fifo_pndng <= 1'b0;
            fifo_data  <= '0;
        end else begin
            if (fifo_pop && (fifo_q.size() > 0)) fifo_data <= fifo_q.pop_front();
            if (push) fifo_q.push_back(push_data);
            fifo_pndng <= (fifo_q.size() != 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every stream word must come out in push order; backpressure must hold the word.
    always @(negedge clk) begin
        if (reset_fifo) begin
            occ        = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, held_data);
            end
            if (fifo_pop) begin
                check("pop_pndng", fifo_pndng, 1);
                check("pop_room", (occ <= 2), 1);
                pop_total++;
            end
            if (m_valid && m_ready) begin
                check("sb_expect", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("sb_data", m_data, exp_q.pop_front());
                hs_total++;
            end
            occ = occ + (fifo_pop ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            stall_prev = m_valid && !m_ready;
            held_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_fifo = 1'b1;
        start = 1'b0; stop = 1'b0; push = 1'b0; m_ready = 1'b0; burst_len = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 reset_fifo = 1'b0;
        tick();
    endtask

    task automatic push_word(input logic [WS-1:0] d);
        push = 1'b1;
        push_data = d;
        exp_q.push_back(d);
        tick();
        push = 1'b0;
    endtask

    task automatic do_start(input int len);
        burst_len = CW'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            tick();
        end
        check(tag, done, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int h0;
        int left;
        int len;

        // Reset state
        do_reset();
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_pop", fifo_pop, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ws", words_sent, 0);

        // Burst of 4, always ready: cycle-exact pops, data and done
        for (int i = 0; i < 4; i++) push_word(WS'(8'hA1 + i));
        m_ready = 1'b1;
        do_start(4);
        for (int i = 0; i < 9; i++) begin
            check("t1_busy", busy, (i < 8));
            check("t1_pop", fifo_pop, (i < 4));
            check("t1_valid", m_valid, (i >= 2 && i <= 5));
            if (i >= 2 && i <= 5) check("t1_data", m_data, 8'hA1 + i - 2);
            check("t1_done", done, (i == 7));
            tick();
        end
        check("t1_ws", words_sent, 4);

        // Burst of 6 from a full FIFO under 10 cycles of backpressure
        do_reset();
        for (int i = 0; i < 8; i++) push_word(WS'(8'hB0 + i));
        p0 = pop_total; h0 = hs_total;
        do_start(6);
        repeat (9) tick();
        check("t2_pops", pop_total - p0, 3);
        check("t2_valid", m_valid, 1);
        check("t2_head", m_data, 8'hB0);
        m_ready = 1'b1;
        wait_done("t2_done", 100);
        check("t2_ws", words_sent, 6);
        check("t2_hs", hs_total - h0, 6);
        check("t2_left", fifo_q.size(), 2);
        check("t2_pndng", fifo_pndng, 1);

        // Continuous drain, stop 3 cycles after start
        do_reset();
        for (int i = 0; i < 5; i++) push_word(WS'(8'hC0 + i));
        m_ready = 1'b1;
        p0 = pop_total; h0 = hs_total;
        do_start(0);
        tick(); tick(); tick();
        stop = 1'b1;
        #1;
        check("t3_stop_nopop", fifo_pop, 0);
        check("t3_busy", busy, 1);
        tick();
        stop = 1'b0;
        wait_done("t3_done", 50);
        check("t3_pops", pop_total - p0, 3);
        check("t3_ws", words_sent, 3);
        check("t3_left", fifo_q.size(), 2);
        check("t3_pndng", fifo_pndng, 1);

        // Burst longer than FIFO occupancy stalls until refilled
        do_reset();
        push_word(8'hD0);
        m_ready = 1'b1;
        p0 = pop_total;
        do_start(3);
        repeat (6) tick();
        check("t4_stall_busy", busy, 1);
        check("t4_stall_pops", pop_total - p0, 1);
        check("t4_stall_ws", words_sent, 1);
        push_word(8'hD1);
        push_word(8'hD2);
        wait_done("t4_done", 50);
        check("t4_pops", pop_total - p0, 3);
        check("t4_ws", words_sent, 3);

        // Asynchronous reset mid-burst with two buffered words
        do_reset();
        for (int i = 0; i < 8; i++) push_word(WS'(8'hE0 + i));
        do_start(6);
        tick(); tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();
        check("t5_pre_valid", m_valid, 1);
        check("t5_pre_ws", words_sent, 1);
        #2 reset_fifo = 1'b1;
        #1;
        check("t5_valid", m_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_pop", fifo_pop, 0);
        check("t5_ws", words_sent, 0);
        check("t5_data", m_data, 0);
        exp_q.delete();
        #3 reset_fifo = 1'b0;
        tick();
        push_word(8'h5A);
        push_word(8'hA5);
        m_ready = 1'b1;
        do_start(2);
        wait_done("t5_restart_done", 50);
        check("t5_restart_ws", words_sent, 2);

        // Randomized: 200 words, random pushes, 50% ready, random burst lengths
        do_reset();
        h0 = hs_total;
        fork
            begin : pusher
                int n;
                n = 0;
                while (n < 200) begin
                    if (($urandom_range(0, 1) == 1) && (fifo_q.size() < 8)) begin
                        push = 1'b1;
                        push_data = WS'($urandom);
                        exp_q.push_back(push_data);
                        n++;
                    end else begin
                        push = 1'b0;
                    end
                    tick();
                end
                push = 1'b0;
            end
            begin : ready_gen
                while (!rand_done) begin
                    m_ready = ($urandom_range(0, 1) == 1);
                    tick();
                end
                m_ready = 1'b0;
            end
            begin : driver
                left = 200;
                while (left > 0) begin
                    len = $urandom_range(1, 15);
                    if (len > left) len = left;
                    do_start(len);
                    wait_done("t6_done", 2000);
                    check("t6_ws", words_sent, len);
                    left -= len;
                end
                rand_done = 1'b1;
            end
        join
        check("t6_total", hs_total - h0, 200);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
